// File: rtl/mod12_ctrl_arb.sv
// Round-robin arbiter and sequencer for two requesters sharing one mod-MOD up/down counter.
// Each grant loads the counter, lets it run for the requested length, then returns the final count.
module mod12_ctrl_arb #(
  parameter int MOD   = 12,
  parameter int WIDTH = 4,
  parameter int LEN_W = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           req,
  input  logic [2*WIDTH-1:0]   req_data,
  input  logic [1:0]           req_mode,
  input  logic [2*LEN_W-1:0]   req_len,
  output logic [1:0]           grant,
  output logic [1:0]           done,
  output logic [WIDTH-1:0]     result,
  output logic                 err,
  output logic                 busy,
  output logic                 ctr_load,
  output logic                 ctr_mode,
  output logic [WIDTH-1:0]     ctr_data,
  input  logic [WIDTH-1:0]     ctr_count
);

  localparam logic [WIDTH:0] MOD_LIM = (WIDTH+1)'(MOD);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state;
  logic             rr;
  logic             owner;
  logic [LEN_W-1:0] remaining;

  logic             sel;
  logic [WIDTH-1:0] sel_data;
  logic             sel_mode;
  logic [LEN_W-1:0] sel_len;
  logic             oversize;

  // On a tie the rr pointer decides; otherwise the lone requester wins.
  always_comb begin
    sel      = (req == 2'b11) ? rr : req[1];
    sel_data = sel ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
    sel_mode = req_mode[sel];
    sel_len  = sel ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
    oversize = {1'b0, sel_data} >= MOD_LIM;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rr        <= 1'b0;
      owner     <= 1'b0;
      remaining <= '0;
      grant     <= 2'b00;
      done      <= 2'b00;
      result    <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      ctr_load  <= 1'b0;
      ctr_mode  <= 1'b0;
      ctr_data  <= '0;
    end else begin
      done     <= 2'b00;
      err      <= 1'b0;
      ctr_load <= 1'b0;
      ctr_data <= '0;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            owner     <= sel;
            grant     <= sel ? 2'b10 : 2'b01;
            ctr_data  <= oversize ? '0 : sel_data;
            err       <= oversize;
            ctr_mode  <= sel_mode;
            ctr_load  <= 1'b1;
            remaining <= sel_len;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (remaining == '0) begin
            done  <= grant;
            state <= DONE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          // remaining still holds the full length in the first RUN cycle.
          if (remaining == LEN_W'(1)) begin
            done  <= grant;
            state <= DONE;
          end else begin
            remaining <= remaining - LEN_W'(1);
          end
        end
        DONE: begin
          result <= ctr_count;
          rr     <= ~owner;
          grant  <= 2'b00;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod12_ctrl_arb.sv
// Self-checking bench for mod12_ctrl_arb: a transaction-level model predicts every output each
// cycle, a counter model drives ctr_count, and directed operations pin literal results.
module tb_mod12_ctrl_arb;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = '0;
  logic [7:0] req_data = '0;
  logic [1:0] req_mode = '0;
  logic [7:0] req_len = '0;
  logic [1:0] grant, done;
  logic [3:0] result;
  logic       err, busy, ctr_load, ctr_mode;
  logic [3:0] ctr_data;
  logic [3:0] ctr_count;

  int  num_checks = 0;
  int  num_fail = 0;
  bit  check_en = 1'b0;

  mod12_ctrl_arb #(.MOD(12), .WIDTH(4), .LEN_W(4)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data), .req_mode(req_mode),
    .req_len(req_len), .grant(grant), .done(done), .result(result), .err(err), .busy(busy),
    .ctr_load(ctr_load), .ctr_mode(ctr_mode), .ctr_data(ctr_data), .ctr_count(ctr_count)
  );

  always #5 clock = ~clock;

  // External mod-12 up/down counter that the block drives.
  int cnt = 0;
  assign ctr_count = 4'(cnt);
  always @(posedge clock) begin
    if (ctr_load) cnt <= int'(ctr_data);
    else if (ctr_mode) cnt <= (cnt + 1) % 12;
    else cnt <= (cnt + 11) % 12;
  end

  // Operation-level model: one active operation, k = cycles since the arbitration edge.
  bit m_active = 0;
  int m_k = 0, m_owner = 0, m_rr = 0, m_start = 0, m_len = 0, m_err = 0;
  int m_mode = 0, m_result = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_active = 0; m_k = 0; m_rr = 0; m_mode = 0; m_result = 0; m_err = 0;
    end else if (m_active) begin
      m_k++;
      if (m_k == m_len + 3) begin
        m_active = 0;
        m_rr = 1 - m_owner;
        m_result = (((m_start + (m_mode != 0 ? m_len : -m_len)) % 12) + 12) % 12;
      end
    end else if (req != 2'b00) begin
      m_owner = (req == 2'b11) ? m_rr : (req[1] ? 1 : 0);
      m_start = (m_owner == 1) ? int'(req_data[7:4]) : int'(req_data[3:0]);
      m_len   = (m_owner == 1) ? int'(req_len[7:4]) : int'(req_len[3:0]);
      m_mode  = int'(req_mode[m_owner]);
      m_err   = (m_start >= 12) ? 1 : 0;
      if (m_start >= 12) m_start = 0;
      m_active = 1;
      m_k = 1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    num_checks++;
    if (actual !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      int og;
      og = m_active ? (m_owner == 1 ? 2 : 1) : 0;
      checkOutput("m_grant", int'(grant), og);
      checkOutput("m_busy", int'(busy), m_active ? 1 : 0);
      checkOutput("m_done", int'(done), (m_active && m_k == m_len + 2) ? og : 0);
      checkOutput("m_load", int'(ctr_load), (m_active && m_k == 1) ? 1 : 0);
      checkOutput("m_data", int'(ctr_data), (m_active && m_k == 1) ? m_start : 0);
      checkOutput("m_err", int'(err), (m_active && m_k == 1) ? m_err : 0);
      checkOutput("m_mode", int'(ctr_mode), m_mode);
      checkOutput("m_result", int'(result), m_result);
    end
  end

  task automatic applyStimulus(input logic [1:0] rq, input int d0, input int m0, input int l0,
                               input int d1, input int m1, input int l1);
    req      = rq;
    req_data = {4'(d1), 4'(d0)};
    req_mode = {1'(m1), 1'(m0)};
    req_len  = {4'(l1), 4'(l0)};
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Starts at a negedge with the block idle; ends at the negedge of the idle cycle after DONE.
  task automatic runOp(input string name, input logic [1:0] rq, input int d0, input int m0,
                       input int l0, input int d1, input int m1, input int l1,
                       input int exp_grant, input int exp_start, input int exp_err,
                       input int exp_len, input int exp_result);
    int k;
    bit seen;
    applyStimulus(rq, d0, m0, l0, d1, m1, l1);
    @(posedge clock);
    #1;
    applyStimulus(2'b00, $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 15));
    k = 0;
    seen = 0;
    while (k < 40 && !seen) begin
      @(negedge clock);
      k++;
      if (k == 1) begin
        checkOutput({name, "_grant"}, int'(grant), exp_grant);
        checkOutput({name, "_load"}, int'(ctr_load), 1);
        checkOutput({name, "_data"}, int'(ctr_data), exp_start);
        checkOutput({name, "_err"}, int'(err), exp_err);
      end
      if (done != 2'b00) seen = 1;
    end
    checkOutput({name, "_done"}, int'(done), exp_grant);
    checkOutput({name, "_latency"}, k, exp_len + 2);
    @(negedge clock);
    checkOutput({name, "_result"}, int'(result), exp_result);
    checkOutput({name, "_idle"}, int'(grant), 0);
  endtask

  initial begin
    logic [1:0] g [1:17];
    @(negedge clock);
    doReset();
    check_en = 1'b1;
    checkOutput("rst_grant", int'(grant), 0);
    checkOutput("rst_result", int'(result), 0);
    checkOutput("rst_busy", int'(busy), 0);

    runOp("up5", 2'b01, 2, 1, 5, 0, 0, 0, 1, 2, 0, 5, 7);
    runOp("down8", 2'b10, 0, 0, 0, 5, 0, 8, 2, 5, 0, 8, 9);

    doReset();
    applyStimulus(2'b11, 0, 1, 3, 6, 0, 3);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clock);
      g[i] = grant;
    end
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    checkOutput("rr_g1", int'(g[1]), 1);
    checkOutput("rr_g5", int'(g[5]), 1);
    checkOutput("rr_g6", int'(g[6]), 0);
    checkOutput("rr_g7", int'(g[7]), 2);
    checkOutput("rr_g12", int'(g[12]), 0);
    checkOutput("rr_g13", int'(g[13]), 1);

    runOp("wrapup", 2'b01, 10, 1, 4, 0, 0, 0, 1, 10, 0, 4, 2);
    runOp("oversize", 2'b10, 0, 0, 0, 13, 0, 1, 2, 0, 1, 1, 11);
    runOp("len0", 2'b01, 8, 1, 0, 0, 0, 0, 1, 8, 0, 0, 8);

    applyStimulus(2'b01, 3, 1, 10, 0, 0, 0);
    @(posedge clock);
    #1;
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("midrst_grant", int'(grant), 0);
    checkOutput("midrst_done", int'(done), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_result", int'(result), 0);
    checkOutput("midrst_data", int'(ctr_data) + int'(ctr_load) + int'(ctr_mode) + int'(err), 0);
    runOp("afterrst", 2'b11, 4, 1, 2, 7, 0, 2, 1, 4, 0, 2, 6);

    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 149) == 0);
      applyStimulus(($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3)),
                    $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 12),
                    $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 12));
      @(negedge clock);
    end
    reset = 1'b0;
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
    repeat (20) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fail);
    $finish;
  end

endmodule

// File: doc/mod12_ctrl_arb.md
Name: mod12_ctrl_arb

Overview:
- Two-requester round-robin arbiter and sequencer for one shared mod12 up/down counter.
- Each granted requester supplies a start value, a direction and a run length.
- The block loads the counter, lets it run for exactly the requested number of cycles, then captures the final count and returns it with a done pulse.
- Sits between requester logic and the counter's load/mode/data_in/count_out pins.

Parameters:
- MOD, 12, counter modulus; legal counter values 0..MOD-1.
- WIDTH, 4, counter value width.
- LEN_W, 4, run-length field width.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  2  level request, bit i = requester i.
- req_data  in  2*WIDTH  start values; bits [WIDTH-1:0] for requester 0, [2*WIDTH-1:WIDTH] for requester 1.
- req_mode  in  2  direction per requester: 1 = up, 0 = down.
- req_len  in  2*LEN_W  run length per requester, same packing as req_data.
- grant  out  2  one-hot owner of the counter; 0 when idle.
- done  out  2  one-cycle pulse to the owning requester at completion.
- result  out  WIDTH  final count captured at completion; held until the next completion.
- err  out  1  one-cycle pulse when a latched start value is >= MOD.
- busy  out  1  high in LOAD, RUN and DONE.
- ctr_load  out  1  to counter load.
- ctr_mode  out  1  to counter mode.
- ctr_data  out  WIDTH  to counter data_in.
- ctr_count  in  WIDTH  from counter count_out.

Behaviour:
- Reset (synchronous, any state): state=IDLE, rr pointer=0 (requester 0 favoured), and all outputs 0.
- Counter model:
  - load=1 at an edge: count <= data.
  - Otherwise up: 11 -> 0 wrap; down: 0 -> 11 wrap.
- IDLE:
  - If any req bit is high, select by round-robin: the favoured requester wins a tie; a lone requester always wins.
  - Latch that requester's data, mode and len.
  - Register grant one-hot and go to LOAD.
  - No req: stay in IDLE, all control outputs low.
- Start-value check: a latched start value >= MOD is replaced by 0, and err pulses in the LOAD cycle.
- LOAD (1 cycle): ctr_load=1, ctr_data=start, ctr_mode=dir. Next state is RUN if len != 0, else DONE.
- RUN:
  - ctr_load=0, ctr_mode=dir held; the remaining counter is preloaded with len and decrements each cycle.
  - Leave to DONE on the cycle remaining==1.
  - RUN lasts exactly len cycles.
- DONE (1 cycle):
  - result <= ctr_count; done[owner]=1.
  - rr pointer <= other requester.
  - Next cycle: grant=0, state IDLE.
- Required result: up gives (start+len) mod 12; down gives (start-len) mod 12; len=0 gives start.
- Latency: req sampled in IDLE cycle n; grant/LOAD in n+1; done in n+2+len. Minimum gap between back-to-back grants is one IDLE cycle.
- Command stability: inputs are sampled only at arbitration. Changes to req_* or deassertion of req during LOAD/RUN/DONE have no effect; an operation is never aborted except by reset.
- Other requests: a request from the non-owner during an operation waits; it wins the next arbitration because the pointer moves to it.
- Reset mid-operation: immediate return to IDLE; no done pulse; result cleared to 0.
- Idle outputs: ctr_mode holds its last value and ctr_data holds 0 outside LOAD. Counter activity outside LOAD/RUN is ignored.

Test Plan:
- Reset then req=01, data0=2, mode0=1, len0=5 -> grant=01 one cycle later, ctr_load high one cycle with ctr_data=2, done=01 at n+7, result=7.
- req=10, data1=5, mode1=0, len1=8 -> wrap down through 0, result=9, done=10, grant returns to 00.
- req=11 held continuously, len=3 each -> grants alternate 01,10,01 with one idle cycle between operations; rr starts at 0 after reset.
- data0=10, up, len=4 -> result=2 (wrap 11 -> 0). Separately, data1=13 -> err pulse in the LOAD cycle, start forced to 0, down len=1 gives result=11.
- len=0, data0=8 -> LOAD then DONE directly, result=8, done at n+2.
- Assert reset during RUN of a len=10 op -> next cycle all outputs 0 with no done pulse; a subsequent request is served normally from requester 0.
